// File: rtl/hazard_detection_unit.sv
// Purpose: ID-stage load/data hazard detector for a 5-stage pipeline.
//   Tracks the instructions that have left ID in two shadow slots (EXE, MEM)
//   and raises a stall request when the ID instruction reads a register that
//   one of them will still write. The WB stage is not tracked: the register
//   file writes in the first half-cycle, so a WB producer is already visible.
// Configuration macro: FORWARDING_EN
//   undefined - stall on any EXE- or MEM-slot match (no bypass network)
//   defined   - stall only on a load-use match in the EXE slot
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   id_valid          ID stage holds a real instruction
//   src1, src2, dest  ID-stage register numbers
//   WB_EN, MEM_R_EN   ID-stage controller: writes a register / is a load
//   Is_Imm, ST_or_BNE ID-stage controller: immediate form / store or BNE
//   branch_taken      EXE resolved a taken branch or jump (flush ID)
//   hazard_detected   combinational stall request to controller, PC, IF/ID
//   stall_cycles      saturating count of stalled cycles
module hazard_detection_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [4:0]  dest,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        Is_Imm,
  input  logic        ST_or_BNE,
  input  logic        branch_taken,
  output logic        hazard_detected,
  output logic [15:0] stall_cycles
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } slot_t;

  slot_t exe_slot;
  slot_t mem_slot;
  slot_t exe_next;
  logic  uses_src2;
  logic  exe_hit;
  logic  mem_hit;
  logic  raw_hazard;
  logic  unused_bits;

  // A slot matches a source when it will write that (nonzero) register.
  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] src);
    return s.valid && s.wb_en && (src != '0) && (s.dest == src);
  endfunction

  // Dependency detection against both in-flight slots.
  always_comb begin
    uses_src2 = !Is_Imm || ST_or_BNE;
    exe_hit   = slot_match(exe_slot, src1) || (uses_src2 && slot_match(exe_slot, src2));
    mem_hit   = slot_match(mem_slot, src1) || (uses_src2 && slot_match(mem_slot, src2));
`ifdef FORWARDING_EN
    // Everything but a load one cycle ahead is covered by the bypass network.
    raw_hazard  = exe_hit && exe_slot.mem_r_en;
    unused_bits = mem_hit ^ mem_slot.mem_r_en;
`else
    raw_hazard  = exe_hit || mem_hit;
    unused_bits = mem_slot.mem_r_en;
`endif
    // A flushed or empty ID slot never stalls; reset also masks the request.
    hazard_detected = !rst && id_valid && !branch_taken && raw_hazard;
  end

  // A stalled or flushed ID instruction enters EXE as a bubble.
  always_comb begin
    exe_next = '0;
    if (!hazard_detected && !branch_taken) begin
      exe_next.valid    = id_valid;
      exe_next.dest     = dest;
      exe_next.wb_en    = WB_EN;
      exe_next.mem_r_en = MEM_R_EN;
    end
  end

  // Slot pipeline and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_slot     <= '0;
      mem_slot     <= '0;
      stall_cycles <= '0;
    end else begin
      mem_slot <= exe_slot;
      exe_slot <= exe_next;
      if (hazard_detected && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit. A behavioural model keeps the
// register written by each of the last two issued instructions and derives
// the stall request from dependency distance; literal checks pin key cases.
module tb_hazard_detection_unit;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  src1, src2, dest;
  logic        WB_EN, MEM_R_EN, Is_Imm, ST_or_BNE, branch_taken;
  logic        hazard_detected;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_detection_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .src1(src1), .src2(src2), .dest(dest),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .Is_Imm(Is_Imm), .ST_or_BNE(ST_or_BNE),
    .branch_taken(branch_taken),
    .hazard_detected(hazard_detected), .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  // Issue history: index 0 = distance 1, index 1 = distance 2.
  logic        h_wr [2];
  logic [4:0]  h_reg[2];
  logic        h_ld [2];
  logic [15:0] m_cnt;
  logic        mh;
  logic        last_hz;
  int          hz_run;
  logic [15:0] saved_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hazard();
    logic hit = 1'b0;
    logic reads2 = !Is_Imm || ST_or_BNE;
    if (rst || !id_valid || branch_taken) return 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (h_wr[d] && h_reg[d] != 5'd0 &&
          (h_reg[d] == src1 || (reads2 && h_reg[d] == src2))) begin
        if (!FWD) hit = 1'b1;
        else if (d == 0 && h_ld[0]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      h_wr[d] = 1'b0; h_reg[d] = 5'd0; h_ld[d] = 1'b0;
    end
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input logic r, input logic v, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic wb, input logic mr, input logic imm,
                      input logic sb, input logic br);
    rst = r; id_valid = v; src1 = a; src2 = b; dest = d;
    WB_EN = wb; MEM_R_EN = mr; Is_Imm = imm; ST_or_BNE = sb; branch_taken = br;
    #1;
    mh = model_hazard();
    check("hazard", hazard_detected, mh);
    check("stall_cycles", stall_cycles, m_cnt);
    last_hz = hazard_detected;
    if (hazard_detected) hz_run++;
    @(posedge clk);
    if (r) begin
      clear_model();
      m_cnt = 16'd0;
    end else begin
      h_wr[1] = h_wr[0]; h_reg[1] = h_reg[0]; h_ld[1] = h_ld[0];
      h_wr[0]  = v && !mh && !br && wb;
      h_reg[0] = d;
      h_ld[0]  = mr;
      if (mh && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(negedge clk);
  endtask

  // Hold an instruction in ID until the model lets it issue (bounded).
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic wb, input logic mr, input logic imm, input logic sb);
    int n = 0;
    do begin
      step(1'b0, 1'b1, a, b, d, wb, mr, imm, sb, 1'b0);
      n++;
    end while (mh && n < 6);
    check("issue_bound", mh, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; src1 = '0; src2 = '0; dest = '0;
    WB_EN = 1'b0; MEM_R_EN = 1'b0; Is_Imm = 1'b0; ST_or_BNE = 1'b0; branch_taken = 1'b0;
    clear_model();
    m_cnt = 16'd0; mh = 1'b0; last_hz = 1'b0; hz_run = 0; saved_cnt = 16'd0;
    @(posedge clk);
    @(negedge clk);

    // Reset state, with a would-be match on the ID inputs.
    step(1'b1, 1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_hazard", last_hz, 1'b0);
    check("reset_count", stall_cycles, 16'd0);

    // ADD r3,r1,r2 ; SUB r4,r3,r5
    hz_run = 0;
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("add_sub_stalls", hz_run, FWD ? 0 : 2);
    check("add_sub_count", stall_cycles, FWD ? 16'd0 : 16'd2);

    // r0 producer then r0 consumer
    nop(); nop();
    hz_run = 0;
    issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("r0_stalls", hz_run, 0);

    // ADDI r3,r1,#5 ; immediate form with src2=r3 does not read src2
    nop(); nop();
    hz_run = 0;
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(5'd7, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    check("imm_src2_stalls", hz_run, 0);
    // Same, but a store/BNE reads src2
    nop(); nop();
    hz_run = 0;
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("st_src2_stalls", hz_run, FWD ? 0 : 2);

    // LD r6 ; ADD r4,r6,r1
    nop(); nop();
    hz_run = 0;
    issue(5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(5'd6, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("load_use_stalls", hz_run, FWD ? 1 : 2);

    // Load-use pending while EXE resolves a taken branch
    nop(); nop();
    issue(5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    saved_cnt = m_cnt;
    step(1'b0, 1'b1, 5'd6, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("branch_hazard", last_hz, 1'b0);
    check("branch_count", stall_cycles, saved_cnt);
    // Flushed r4 writer must be a bubble; the load must have reached MEM.
    step(1'b0, 1'b1, 5'd4, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("branch_next", last_hz, FWD ? 1'b0 : 1'b1);

    // Dependency at distance 2
    nop(); nop();
    hz_run = 0;
    issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(5'd9, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("dist2_stalls", hz_run, FWD ? 0 : 1);

    // Reset mid-stall
    nop(); nop();
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_stall", last_hz, 1'b1);
    step(1'b1, 1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("in_reset_hazard", last_hz, 1'b0);
    step(1'b0, 1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_hazard", last_hz, 1'b0);

    // Saturation from 16'hFFFE
    nop(); nop();
    force dut.stall_cycles = 16'hFFFE;
    #1;
    release dut.stall_cycles;
    m_cnt = 16'hFFFE;
    hz_run = 0;
    issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(5'd3, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(5'd8, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_stalls", hz_run, FWD ? 2 : 4);
    check("sat_count", stall_cycles, 16'hFFFF);

    // One reset cycle clears the counter and both slots
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd8, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_count", stall_cycles, 16'd0);
    check("rst_slots", last_hz, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
